mem_wb_skid_stage: RTL and testbench

Elastic MEM/WB pipeline stage for the RISC-V core, parametrised in data and register-address width. It uses a valid/ready handshake with a two-entry skid buffer, so a write-back stall does not cause a combinational ready path back into MEM. The write-back source is selected at capture time, and the stage exposes a forwarding tap for the EX hazard unit. It sits between the data-memory stage and the register-file write port, and replaces the plain always-capture MEM/WB register.

---
 rtl/mem_wb_skid_stage_pkg.sv | 18 +
 rtl/mem_wb_skid_stage_if.sv | 43 ++++
 rtl/mem_wb_skid_stage_entry.sv | 30 +++
 rtl/mem_wb_skid_stage.sv | 149 ++++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_skid_stage_pkg.sv
// Shared types for the MEM/WB elastic stage: write-back source select and
// occupancy state of the two-entry skid buffer.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wb_skid_stage_if.sv
// MEM -> WB handshake bundle plus the forwarding tap toward the EX hazard unit.
interface mem_wb_skid_stage_if
  import mem_wb_pkg::*;
#(
  parameter int DATA_BITS     = 32,
  parameter int REG_ADDR_BITS = 5
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_reg_write;
  wb_sel_e                  in_wb_sel;
  logic [DATA_BITS-1:0]     in_alu_result;
  logic [DATA_BITS-1:0]     in_mem_data;
  logic [DATA_BITS-1:0]     in_pc_plus4;
  logic [REG_ADDR_BITS-1:0] in_rd;

  logic                     out_valid;
  logic                     out_ready;
  logic                     out_reg_write;
  logic [REG_ADDR_BITS-1:0] out_rd;
  logic [DATA_BITS-1:0]     out_wb_data;

  logic                     fwd_valid;
  logic [REG_ADDR_BITS-1:0] fwd_rd;
  logic [DATA_BITS-1:0]     fwd_data;

  // Upstream MEM stage and downstream WB port seen from outside the stage.
  modport master (
    output in_valid, in_reg_write, in_wb_sel, in_alu_result, in_mem_data,
           in_pc_plus4, in_rd, out_ready,
    input  in_ready, out_valid, out_reg_write, out_rd, out_wb_data,
           fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  in_valid, in_reg_write, in_wb_sel, in_alu_result, in_mem_data,
           in_pc_plus4, in_rd, out_ready,
    output in_ready, out_valid, out_reg_write, out_rd, out_wb_data,
           fwd_valid, fwd_rd, fwd_data
  );

endinterface

// File: rtl/mem_wb_skid_stage_entry.sv
// One buffered write-back entry {reg_write, rd, wb_data}; loads on demand,
// cleared only by reset since validity is tracked by the owner's state.
module mem_wb_entry #(
  parameter int DATA_BITS     = 32,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     reg_write_d,
  input  logic [REG_ADDR_BITS-1:0] rd_d,
  input  logic [DATA_BITS-1:0]     wb_data_d,
  output logic                     reg_write_q,
  output logic [REG_ADDR_BITS-1:0] rd_q,
  output logic [DATA_BITS-1:0]     wb_data_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wb_data_q   <= '0;
    end else if (load) begin
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// Elastic MEM/WB stage: two-entry skid buffer so WB stalls never reach MEM
// combinationally; write-back source is resolved when the entry is captured.
module mem_wb_skid_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_BITS     = 32,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  mem_wb_skid_stage_if.slave   bus
);

  state_e state_q, state_d;

  logic in_ready, out_valid;
  logic in_fire, out_fire;
  logic main_load, skid_load, main_from_skid;

  logic                     cap_reg_write;
  logic [REG_ADDR_BITS-1:0] cap_rd;
  logic [DATA_BITS-1:0]     cap_wb_data;

  logic                     main_reg_write_d, main_reg_write_q;
  logic [REG_ADDR_BITS-1:0] main_rd_d, main_rd_q;
  logic [DATA_BITS-1:0]     main_wb_data_d, main_wb_data_q;

  logic                     skid_reg_write_q;
  logic [REG_ADDR_BITS-1:0] skid_rd_q;
  logic [DATA_BITS-1:0]     skid_wb_data_q;

  // Writes to x0 are dropped here so downstream never has to re-check rd.
  always_comb begin
    cap_rd        = bus.in_rd;
    cap_reg_write = bus.in_reg_write & (bus.in_rd != '0);
    case (bus.in_wb_sel)
      WB_MEM:  cap_wb_data = bus.in_mem_data;
      WB_PC4:  cap_wb_data = bus.in_pc_plus4;
      default: cap_wb_data = bus.in_alu_result;
    endcase
  end

  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // SKID always holds the younger entry, so it only ever refills MAIN.
          if (out_fire) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs are pure state decodes: no out_ready -> in_ready path.
  always_comb begin
    in_ready          = (state_q != TWO);
    out_valid         = (state_q != EMPTY);
    bus.in_ready      = in_ready;
    bus.out_valid     = out_valid;
    bus.out_reg_write = out_valid & main_reg_write_q;
    bus.out_rd        = main_rd_q;
    bus.out_wb_data   = main_wb_data_q;
    bus.fwd_valid     = out_valid & main_reg_write_q;
    bus.fwd_rd        = main_rd_q;
    bus.fwd_data      = main_wb_data_q;
  end

  always_comb begin
    if (main_from_skid) begin
      main_reg_write_d = skid_reg_write_q;
      main_rd_d        = skid_rd_q;
      main_wb_data_d   = skid_wb_data_q;
    end else begin
      main_reg_write_d = cap_reg_write;
      main_rd_d        = cap_rd;
      main_wb_data_d   = cap_wb_data;
    end
  end

  mem_wb_entry #(
    .DATA_BITS     (DATA_BITS),
    .REG_ADDR_BITS (REG_ADDR_BITS)
  ) u_main (
    .clk         (clk),
    .rst         (rst),
    .load        (main_load),
    .reg_write_d (main_reg_write_d),
    .rd_d        (main_rd_d),
    .wb_data_d   (main_wb_data_d),
    .reg_write_q (main_reg_write_q),
    .rd_q        (main_rd_q),
    .wb_data_q   (main_wb_data_q)
  );

  mem_wb_entry #(
    .DATA_BITS     (DATA_BITS),
    .REG_ADDR_BITS (REG_ADDR_BITS)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .load        (skid_load),
    .reg_write_d (cap_reg_write),
    .rd_d        (cap_rd),
    .wb_data_d   (cap_wb_data),
    .reg_write_q (skid_reg_write_q),
    .rd_q        (skid_rd_q),
    .wb_data_q   (skid_wb_data_q)
  );

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Scoreboard bench for mem_wb_skid_stage: a FIFO-of-capacity-2 reference model
// fed at each accepted input, checked by a free-running monitor.
module tb_mem_wb_skid_stage;
  import mem_wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  mem_wb_skid_stage_if #(.DATA_BITS(32), .REG_ADDR_BITS(5)) bus ();

  mem_wb_skid_stage #(.DATA_BITS(32), .REG_ADDR_BITS(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t model_capture(int sel, logic [31:0] alu, logic [31:0] mem,
                                         logic [31:0] pc4, logic [4:0] rd, logic rw);
    ent_t e;
    if (sel == 1)      e.data = mem;
    else if (sel == 2) e.data = pc4;
    else               e.data = alu;
    e.rd = rd;
    e.rw = rw && (rd != 5'd0);
    return e;
  endfunction

  // Monitor: inputs change only just after posedge, so negedge sees the values
  // that decide the next edge. The model is a plain bounded FIFO of depth 2.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      bit m_in_fire, m_out_fire;
      m_in_fire  = bus.in_valid && (sb.size() < 2);
      m_out_fire = bus.out_ready && (sb.size() != 0);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, sb.size() < 2});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
      if (sb.size() != 0) begin
        chk("out_wb_data", bus.out_wb_data, sb[0].data);
        chk("out_rd", {27'd0, bus.out_rd}, {27'd0, sb[0].rd});
        chk("out_reg_write", {31'd0, bus.out_reg_write}, {31'd0, sb[0].rw});
        chk("fwd_valid", {31'd0, bus.fwd_valid}, {31'd0, sb[0].rw});
        chk("fwd_rd", {27'd0, bus.fwd_rd}, {27'd0, sb[0].rd});
        chk("fwd_data", bus.fwd_data, sb[0].data);
      end
      if (m_out_fire) begin
        $display("txn out rd=%0d rw=%0d data=%h", sb[0].rd, sb[0].rw, sb[0].data);
        void'(sb.pop_front());
      end
      if (flush) begin
        sb.delete();
      end else if (m_in_fire) begin
        sb.push_back(model_capture(int'(bus.in_wb_sel), bus.in_alu_result, bus.in_mem_data,
                                   bus.in_pc_plus4, bus.in_rd, bus.in_reg_write));
      end
    end
  end

  task automatic cyc(bit v, bit [1:0] sel, logic [31:0] alu, logic [31:0] mem,
                     logic [31:0] pc4, logic [4:0] rd, bit rw, bit ordy, bit fl);
    bus.in_valid      = v;
    bus.in_wb_sel     = wb_sel_e'(sel);
    bus.in_alu_result = alu;
    bus.in_mem_data   = mem;
    bus.in_pc_plus4   = pc4;
    bus.in_rd         = rd;
    bus.in_reg_write  = rw;
    bus.out_ready     = ordy;
    flush             = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit ordy, int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, ordy, 1'b0);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_out_reg_write"}, {31'd0, bus.out_reg_write}, 32'd0);
    chk({tag, "_out_rd"}, {27'd0, bus.out_rd}, 32'd0);
    chk({tag, "_out_wb_data"}, bus.out_wb_data, 32'd0);
    chk({tag, "_fwd_valid"}, {31'd0, bus.fwd_valid}, 32'd0);
    chk({tag, "_fwd_rd"}, {27'd0, bus.fwd_rd}, 32'd0);
    chk({tag, "_fwd_data"}, bus.fwd_data, 32'd0);
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_wb_sel     = WB_ALU;
    bus.in_alu_result = '0;
    bus.in_mem_data   = '0;
    bus.in_pc_plus4   = '0;
    bus.in_rd         = '0;
    bus.in_reg_write  = 1'b0;
    bus.out_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;
    idle(1'b1, 1);

    // Streaming, 8 back-to-back
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 2'd0, 32'h10 + i, $urandom, $urandom, 5'(i + 1), 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Backpressure: A, B held, then drained
    cyc(1'b1, 2'd0, 32'hA, $urandom, $urandom, 5'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 32'hB, $urandom, $urandom, 5'd2, 1'b1, 1'b0, 1'b0);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_head", bus.out_wb_data, 32'hA);
    idle(1'b1, 1);
    chk("bp_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_second", bus.out_wb_data, 32'hB);
    idle(1'b1, 2);

    // Source select
    for (int s = 0; s < 4; s++)
      cyc(1'b1, 2'(s), 32'h1, 32'h2, 32'h3, 5'd3, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);

    // x0 guard
    cyc(1'b1, 2'd0, 32'h55, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("x0_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("x0_out_reg_write", {31'd0, bus.out_reg_write}, 32'd0);
    chk("x0_fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
    idle(1'b1, 2);

    // Flush in TWO with a concurrent input
    cyc(1'b1, 2'd0, 32'h21, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 32'h22, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 32'hDEAD, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    idle(1'b1, 3);

    // Async reset while in ONE
    cyc(1'b1, 2'd1, 32'h0, 32'h77, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_zero_outputs("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_zero_outputs("post_rst");
    idle(1'b1, 1);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
          rd, 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    idle(1'b1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
